mor1kx_branch_predictor_unit: RTL and testbench
===============================================

// Module: mor1kx_branch_predictor_unit
// PURPOSE
//  Conditional-branch direction predictor for the decode stage.
//  - Mode is selected by a parameter:
//    - SIMPLE: static backward-taken rule.
//    - SAT_COUNTER: one global 2-bit counter.
//    - GSHARE: PC-xor-history indexed table of 2-bit counters.
//  - Emits the predicted flag for the branch in decode.
//  - Flags a misprediction when the real flag resolves one stage later.
// PARAMETERS
//  FEATURE_BRANCH_PREDICTOR  "SAT_COUNTER"  "SIMPLE" | "SAT_COUNTER" | "GSHARE";
//                                           any other value: $display error + $finish at elaboration
//  OPTION_OPERAND_WIDTH      32             width of brn_pc_i
//  GSHARE_BITS               10             history length and table index width (table = 2**GSHARE_BITS entries)
// PORTS
//  clk                    in   1     clock, rising edge
//  rst                    in   1     reset, asynchronous, active-high
//  op_bf_i                in   1     decode insn is l.bf
//  op_bnf_i               in   1     decode insn is l.bnf
//  immjbr_upper_i         in   10    decode branch imm upper bits; [9] = sign (1 = backward)
//  brn_pc_i               in   OOW   PC of the decode branch
//  predicted_flag_o       out  1     predicted "take" for the decode branch
//  prev_op_brcond_i       in   1     insn in execute is a conditional branch
//  prev_predicted_flag_i  in   1     prediction made for that insn
//  flag_i                 in   1     resolved SR[F]
//  padv_decode_i          in   1     decode stage advances this cycle
//  execute_bf_i           in   1     execute insn is l.bf
//  execute_bnf_i          in   1     execute insn is l.bnf
//  branch_mispredict_o    out  1     resolved branch was mispredicted
// BEHAVIOUR
//  Mispredict detection (all modes, combinational):
//   - branch_mispredict_o = prev_op_brcond_i & (flag_i != prev_predicted_flag_i).
//  Resolved direction:
//   - taken = (execute_bf_i & flag_i) | (execute_bnf_i & ~flag_i).
//   - Update enable: upd = prev_op_brcond_i & padv_decode_i.
//   - No state changes when upd = 0.
//  Counter encoding (2-bit saturating):
//   - 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
//   - On taken: +1, saturating at 11. On not taken: -1, saturating at 00.
//   - Predict taken when cnt[1] = 1.
//  Prediction-to-flag mapping (all counter modes, combinational):
//   - predicted_flag_o = (op_bf_i & T) | (op_bnf_i & ~T), where T is the predicted-taken bit.
//   - predicted_flag_o = 0 when neither op_bf_i nor op_bnf_i is set.
//  SIMPLE:
//   - T = immjbr_upper_i[9].
//   - No state; clk/rst unused.
//  SAT_COUNTER:
//   - T = cnt[1] of a single global counter.
//   - Reset value 10 (weakly taken).
//  GSHARE:
//   - hist: GSHARE_BITS-bit register, reset 0.
//   - idx = brn_pc_i[GSHARE_BITS+1:2] ^ hist; T = table[idx][1].
//   - Every table entry resets to 10 (weakly taken).
//   - prev_idx register, reset 0, loads idx when padv_decode_i = 1; holds otherwise.
//   - On upd: table[prev_idx] updates per the counter rule.
//   - On upd: hist <= {hist[GSHARE_BITS-2:0], taken}.
//  Timing and conflicts:
//   - Predictions read pre-update state: an update and a prediction in the same cycle,
//     same entry, yield the old value. Updated state is visible the next cycle.
//   - Reset mid-operation immediately forces all state to reset values.
//   - Combinational outputs follow inputs with zero latency.
//   - Only one table entry is written per cycle.
// STRUCTURE
//  - Shared package mor1kx_bp_pkg: 2-bit counter state constants (SNT/WNT/WT/ST)
//    and function sat_next(cnt, taken).
//  - Sub-module mor1kx_bp_sat_counter: one 2-bit counter with async reset to 10,
//    inputs en and taken, output cnt. Used once in SAT_COUNTER mode; the GSHARE
//    table may reuse sat_next.
//  - Mode selected by a generate block on FEATURE_BRANCH_PREDICTOR.
// TESTING
//  1. SIMPLE: op_bf_i=1, imm[9]=1 -> pred 1. op_bf_i=1, imm[9]=0 -> pred 0.
//     op_bnf_i=1, imm[9]=0 -> pred 1. Neither op set -> pred 0.
//  2. Mispredict: prev_op_brcond_i=1, flag_i=1, prev_predicted_flag_i=0 -> mispredict=1.
//     Same case with prev_op_brcond_i=0 -> mispredict=0.
//  3. SAT_COUNTER: after reset, op_bf_i=1 -> pred 1.
//     Two not-taken updates (execute_bf_i=1, flag_i=0, upd) -> cnt 00, op_bf_i pred 0, op_bnf_i pred 1.
//     Three taken updates -> cnt 11 (saturates).
//  4. Stall: prev_op_brcond_i=1, padv_decode_i=0 for 5 cycles -> counter and hist unchanged.
//  5. GSHARE: brn_pc_i=0x100 (idx 0x040 at hist 0), 2 not-taken updates -> that entry = 00, hist=0x000.
//     A branch at another PC still predicts taken.
//     After one taken update, hist=0x001 and idx for pc 0x100 becomes 0x041.
//  6. Assert rst mid-run -> all counters 10, hist 0, pred for op_bf_i = 1 on the next cycle.

Source files
------------

// File: rtl/mor1kx_bp_pkg.sv
// Shared definitions for the mor1kx branch predictor: 2-bit saturating
// counter encodings and the counter next-state function.
package mor1kx_bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'd1;
      else           nxt = ST;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'd1;
      else            nxt = SNT;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mor1kx_bp_sat_counter.sv
// Single 2-bit saturating direction counter, resets to weakly taken.
module mor1kx_bp_sat_counter
  import mor1kx_bp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  // next counter value
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = sat_next(cnt_q, taken_i);
    else      cnt_d = cnt_q;
  end

  // counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= WT;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mor1kx_branch_predictor_unit.sv
// Decode-stage conditional branch direction predictor with selectable
// SIMPLE / SAT_COUNTER / GSHARE modes and execute-stage mispredict flag.
module mor1kx_branch_predictor_unit
  import mor1kx_bp_pkg::*;
#(
  parameter string FEATURE_BRANCH_PREDICTOR = "SAT_COUNTER",
  parameter int    OPTION_OPERAND_WIDTH     = 32,
  parameter int    GSHARE_BITS              = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            op_bf_i,
  input  logic                            op_bnf_i,
  input  logic [9:0]                      immjbr_upper_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_i,
  output logic                            predicted_flag_o,
  input  logic                            prev_op_brcond_i,
  input  logic                            prev_predicted_flag_i,
  input  logic                            flag_i,
  input  logic                            padv_decode_i,
  input  logic                            execute_bf_i,
  input  logic                            execute_bnf_i,
  output logic                            branch_mispredict_o
);

  logic t_s;
  logic taken_s;
  logic upd_s;
  logic unused_s;

  assign branch_mispredict_o = prev_op_brcond_i & (flag_i != prev_predicted_flag_i);
  assign taken_s = (execute_bf_i & flag_i) | (execute_bnf_i & ~flag_i);
  assign upd_s   = prev_op_brcond_i & padv_decode_i;
  assign predicted_flag_o = (op_bf_i & t_s) | (op_bnf_i & ~t_s);
  assign unused_s = ^{immjbr_upper_i[8:0], brn_pc_i};

  generate
    if (FEATURE_BRANCH_PREDICTOR == "SIMPLE") begin : gen_simple
      logic unused_simple_s;
      // backward branches (negative displacement) are predicted taken
      assign t_s = immjbr_upper_i[9];
      assign unused_simple_s = ^{clk, rst, upd_s, taken_s};
    end else if (FEATURE_BRANCH_PREDICTOR == "SAT_COUNTER") begin : gen_sat
      logic [1:0] cnt_s;
      logic       unused_sat_s;
      mor1kx_bp_sat_counter u_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (upd_s),
        .taken_i (taken_s),
        .cnt_o   (cnt_s)
      );
      assign t_s = cnt_s[1];
      assign unused_sat_s = cnt_s[0];
    end else if (FEATURE_BRANCH_PREDICTOR == "GSHARE") begin : gen_gshare
      localparam int N = 1 << GSHARE_BITS;
      logic [GSHARE_BITS-1:0] hist_q, hist_d;
      logic [GSHARE_BITS-1:0] prev_idx_q, prev_idx_d;
      logic [GSHARE_BITS-1:0] idx_s;
      logic [1:0]             tbl_q [N];

      assign idx_s = brn_pc_i[GSHARE_BITS+1:2] ^ hist_q;
      assign t_s   = tbl_q[idx_s][1];

      // history shift and index of the branch that will resolve next
      always_comb begin
        hist_d     = hist_q;
        prev_idx_d = prev_idx_q;
        if (upd_s) hist_d = {hist_q[GSHARE_BITS-2:0], taken_s};
        else       hist_d = hist_q;
        if (padv_decode_i) prev_idx_d = idx_s;
        else               prev_idx_d = prev_idx_q;
      end

      // history, index and counter table state
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hist_q     <= '0;
          prev_idx_q <= '0;
          for (int i = 0; i < N; i++) tbl_q[i] <= WT;
        end else begin
          hist_q     <= hist_d;
          prev_idx_q <= prev_idx_d;
          if (upd_s) tbl_q[prev_idx_q] <= sat_next(tbl_q[prev_idx_q], taken_s);
        end
      end
    end else begin : gen_invalid
      assign t_s = 1'b0;
      $fatal(1, "mor1kx_branch_predictor_unit: unsupported FEATURE_BRANCH_PREDICTOR");
    end
  endgenerate

endmodule

// File: tb/tb_mor1kx_branch_predictor_unit.sv
// Directed self-checking bench exercising all three predictor modes side by side.
module tb_mor1kx_branch_predictor_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_bf_i, op_bnf_i;
  logic [9:0]  immjbr_upper_i;
  logic [31:0] brn_pc_i;
  logic        prev_op_brcond_i, prev_predicted_flag_i, flag_i;
  logic        padv_decode_i, execute_bf_i, execute_bnf_i;
  logic        pred_simple, pred_sat, pred_gs;
  logic        mis_simple, mis_sat, mis_gs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mor1kx_branch_predictor_unit #(.FEATURE_BRANCH_PREDICTOR("SIMPLE")) u_simple (
    .clk(clk), .rst(rst), .op_bf_i(op_bf_i), .op_bnf_i(op_bnf_i),
    .immjbr_upper_i(immjbr_upper_i), .brn_pc_i(brn_pc_i), .predicted_flag_o(pred_simple),
    .prev_op_brcond_i(prev_op_brcond_i), .prev_predicted_flag_i(prev_predicted_flag_i),
    .flag_i(flag_i), .padv_decode_i(padv_decode_i), .execute_bf_i(execute_bf_i),
    .execute_bnf_i(execute_bnf_i), .branch_mispredict_o(mis_simple));

  mor1kx_branch_predictor_unit #(.FEATURE_BRANCH_PREDICTOR("SAT_COUNTER")) u_sat (
    .clk(clk), .rst(rst), .op_bf_i(op_bf_i), .op_bnf_i(op_bnf_i),
    .immjbr_upper_i(immjbr_upper_i), .brn_pc_i(brn_pc_i), .predicted_flag_o(pred_sat),
    .prev_op_brcond_i(prev_op_brcond_i), .prev_predicted_flag_i(prev_predicted_flag_i),
    .flag_i(flag_i), .padv_decode_i(padv_decode_i), .execute_bf_i(execute_bf_i),
    .execute_bnf_i(execute_bnf_i), .branch_mispredict_o(mis_sat));

  mor1kx_branch_predictor_unit #(.FEATURE_BRANCH_PREDICTOR("GSHARE"), .GSHARE_BITS(10)) u_gs (
    .clk(clk), .rst(rst), .op_bf_i(op_bf_i), .op_bnf_i(op_bnf_i),
    .immjbr_upper_i(immjbr_upper_i), .brn_pc_i(brn_pc_i), .predicted_flag_o(pred_gs),
    .prev_op_brcond_i(prev_op_brcond_i), .prev_predicted_flag_i(prev_predicted_flag_i),
    .flag_i(flag_i), .padv_decode_i(padv_decode_i), .execute_bf_i(execute_bf_i),
    .execute_bnf_i(execute_bnf_i), .branch_mispredict_o(mis_gs));

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One resolved-branch update clocked in: execute insn bf/bnf with flag.
  task automatic do_update(input logic bf, input logic bnf, input logic flg);
    prev_op_brcond_i = 1'b1;
    padv_decode_i    = 1'b1;
    execute_bf_i     = bf;
    execute_bnf_i    = bnf;
    flag_i           = flg;
    @(posedge clk); #1;
    prev_op_brcond_i = 1'b0;
    padv_decode_i    = 1'b0;
    execute_bf_i     = 1'b0;
    execute_bnf_i    = 1'b0;
    flag_i           = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    op_bf_i = 1'b0; op_bnf_i = 1'b0; immjbr_upper_i = 10'h000; brn_pc_i = 32'h0;
    prev_op_brcond_i = 1'b0; prev_predicted_flag_i = 1'b0; flag_i = 1'b0;
    padv_decode_i = 1'b0; execute_bf_i = 1'b0; execute_bnf_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // SIMPLE mode: static backward-taken
    op_bf_i = 1'b1; immjbr_upper_i = 10'h200; #1 check("simple_bf_back", pred_simple, 1'b1);
    immjbr_upper_i = 10'h000;                 #1 check("simple_bf_fwd", pred_simple, 1'b0);
    op_bf_i = 1'b0; op_bnf_i = 1'b1;          #1 check("simple_bnf_fwd", pred_simple, 1'b1);
    immjbr_upper_i = 10'h200;                 #1 check("simple_bnf_back", pred_simple, 1'b0);
    op_bnf_i = 1'b0;                          #1 check("simple_none", pred_simple, 1'b0);

    // Mispredict detection
    prev_op_brcond_i = 1'b1; flag_i = 1'b1; prev_predicted_flag_i = 1'b0;
    #1 check("mis_simple", mis_simple, 1'b1);
    check("mis_gs", mis_gs, 1'b1);
    prev_op_brcond_i = 1'b0; #1 check("mis_nobr", mis_sat, 1'b0);
    prev_op_brcond_i = 1'b1; prev_predicted_flag_i = 1'b1; #1 check("mis_match", mis_sat, 1'b0);
    prev_op_brcond_i = 1'b0; flag_i = 1'b0; prev_predicted_flag_i = 1'b0;
    @(posedge clk); #1;

    // SAT_COUNTER: reset weakly taken, then two not-taken updates
    op_bf_i = 1'b1; #1 check("sat_reset_bf", pred_sat, 1'b1);
    op_bf_i = 1'b0;
    do_update(1'b1, 1'b0, 1'b0);
    op_bf_i = 1'b1; #1 check("sat_wnt_bf", pred_sat, 1'b0);
    op_bf_i = 1'b0;
    do_update(1'b1, 1'b0, 1'b0);
    op_bf_i = 1'b1; #1 check("sat_snt_bf", pred_sat, 1'b0);
    op_bf_i = 1'b0; op_bnf_i = 1'b1; #1 check("sat_snt_bnf", pred_sat, 1'b1);
    op_bnf_i = 1'b0;

    // Stall: branch in execute but decode not advancing -> no update
    prev_op_brcond_i = 1'b1; padv_decode_i = 1'b0; execute_bf_i = 1'b1; flag_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 prev_op_brcond_i = 1'b0; execute_bf_i = 1'b0; flag_i = 1'b0;
    op_bf_i = 1'b1; #1 check("sat_stall_bf", pred_sat, 1'b0);
    op_bf_i = 1'b0;

    // Four taken (bnf with flag 0) updates: 00->01->10->11->11
    for (int i = 0; i < 4; i++) do_update(1'b0, 1'b1, 1'b0);
    op_bf_i = 1'b1; #1 check("sat_st_bf", pred_sat, 1'b1);
    op_bf_i = 1'b0;
    do_update(1'b1, 1'b0, 1'b0);
    op_bf_i = 1'b1; #1 check("sat_sat_wt", pred_sat, 1'b1);
    op_bf_i = 1'b0;
    do_update(1'b1, 1'b0, 1'b0);
    op_bf_i = 1'b1; #1 check("sat_sat_wnt", pred_sat, 1'b0);

    // Asynchronous reset mid-run restores weakly taken immediately
    #2 rst = 1'b1;
    #1 check("sat_async_rst", pred_sat, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    #1 check("sat_after_rst", pred_sat, 1'b1);
    op_bf_i = 1'b0;

    // GSHARE: load prev_idx with idx of pc 0x100 (0x040 at hist 0)
    brn_pc_i = 32'h100; padv_decode_i = 1'b1;
    @(posedge clk); #1;
    prev_op_brcond_i = 1'b1; execute_bf_i = 1'b1; flag_i = 1'b0; op_bf_i = 1'b1;
    #1 check("gs_same_cycle_old", pred_gs, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    prev_op_brcond_i = 1'b0; execute_bf_i = 1'b0; padv_decode_i = 1'b0;
    #1 check("gs_entry_snt", pred_gs, 1'b0);
    brn_pc_i = 32'h200; #1 check("gs_other_pc", pred_gs, 1'b1);
    brn_pc_i = 32'h104; #1 check("gs_hist0_104", pred_gs, 1'b1);

    // One taken update on entry 0x040: hist becomes 1, entry becomes 01
    brn_pc_i = 32'h100;
    do_update(1'b1, 1'b0, 1'b1);
    op_bf_i = 1'b1;
    #1 check("gs_hist1_100", pred_gs, 1'b1);
    brn_pc_i = 32'h104; #1 check("gs_hist1_104", pred_gs, 1'b0);

    // Reset mid-run clears table and history
    rst = 1'b1;
    #1 check("gs_rst_104", pred_gs, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    brn_pc_i = 32'h100; #1 check("gs_rst_100", pred_gs, 1'b1);
    op_bf_i = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
